// File: rtl/mp_add_seq.sv
// -----------------------------------------------------------------------------
// mp_add_seq
//
// Multi-precision add sequencer. It accepts two WORDS*SIZE-bit operands and a
// carry-in, then feeds an external combinational SIZE-bit adder slice one word
// per cycle, least significant word first. The carry is chained between words
// through a register. The full sum and the final carry are returned over a
// valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand request valid
//   in_ready   block can accept operands (high only in IDLE)
//   in_a       operand A, SIZE*WORDS bits
//   in_b       operand B, SIZE*WORDS bits
//   in_ci      carry into word 0
//   add_a      word of A driven to the adder slice (0 outside RUN)
//   add_b      word of B driven to the adder slice (0 outside RUN)
//   add_ci     carry driven to the adder slice (0 outside RUN)
//   add_sum    sum word returned by the adder slice
//   add_co     carry returned by the adder slice
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts the result
//   out_sum    full sum, SIZE*WORDS bits
//   out_co     carry out of the top word
//   busy       high in RUN or DONE
// -----------------------------------------------------------------------------
module mp_add_seq #(
    parameter int SIZE  = 4,
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIZE*WORDS-1:0] in_a,
    input  logic [SIZE*WORDS-1:0] in_b,
    input  logic                  in_ci,
    output logic [SIZE-1:0]       add_a,
    output logic [SIZE-1:0]       add_b,
    output logic                  add_ci,
    input  logic [SIZE-1:0]       add_sum,
    input  logic                  add_co,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIZE*WORDS-1:0] out_sum,
    output logic                  out_co,
    output logic                  busy
);

    localparam int TOTAL = SIZE * WORDS;
    // A single-word operand still needs a one-bit index register.
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic [TOTAL-1:0]  a_reg;
    logic [TOTAL-1:0]  b_reg;
    logic [TOTAL-1:0]  sum_reg;
    logic              carry;
    logic [SIZE-1:0]   a_word;
    logic [SIZE-1:0]   b_word;

    // Word select: pick the operand words addressed by idx. Written as a
    // decoded loop so the index never has to be scaled into a bit offset.
    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx == IDX_W'(w)) begin
                a_word = a_reg[w*SIZE +: SIZE];
                b_word = b_reg[w*SIZE +: SIZE];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_sum    = '0;
        out_co     = 1'b0;
        busy       = 1'b0;
        add_a      = '0;
        add_b      = '0;
        add_ci     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                add_a  = a_word;
                add_b  = b_word;
                // For word 0 the carry register holds the captured in_ci.
                add_ci = carry;
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_sum   = sum_reg;
                out_co    = carry;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, per-word sum collection and carry chaining
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        carry <= in_ci;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (idx == IDX_W'(w)) begin
                            sum_reg[w*SIZE +: SIZE] <= add_sum;
                        end
                    end
                    carry <= add_co;
                    // Hold at the last word so idx never exceeds WORDS-1.
                    if (idx != LAST_IDX) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// -----------------------------------------------------------------------------
// tb_mp_add_seq
//
// Bench for mp_add_seq. Two instances: SIZE=4/WORDS=4 and SIZE=4/WORDS=1, each
// with a behavioural combinational adder slice attached. Expected results are
// pushed into a queue when an operand is accepted and popped when the
// sequencer presents its result.
// -----------------------------------------------------------------------------
module tb_mp_add_seq;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] sum;
        logic        co;
        logic [3:0]  ci_seq;   // bit i = add_ci seen on RUN cycle i
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        co;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst;

    // 4-word instance
    logic        in_valid4, in_ready4, in_ci4;
    logic [15:0] in_a4, in_b4;
    logic [3:0]  add_a4, add_b4, add_sum4;
    logic        add_ci4, add_co4;
    logic        out_valid4, out_ready4, out_co4, busy4;
    logic [15:0] out_sum4;

    // 1-word instance
    logic        in_valid1, in_ready1, in_ci1;
    logic [3:0]  in_a1, in_b1;
    logic [3:0]  add_a1, add_b1, add_sum1;
    logic        add_ci1, add_co1;
    logic        out_valid1, out_ready1, out_co1, busy1;
    logic [3:0]  out_sum1;

    int checks;
    int errors;
    exp_t sb4[$];
    exp_t sb1[$];
    vec_t vecs[7];

    assign {add_co4, add_sum4} = {1'b0, add_a4} + {1'b0, add_b4} + {4'b0, add_ci4};
    assign {add_co1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {4'b0, add_ci1};

    mp_add_seq #(.SIZE(4), .WORDS(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a4), .in_b(in_b4), .in_ci(in_ci4),
        .add_a(add_a4), .add_b(add_b4), .add_ci(add_ci4),
        .add_sum(add_sum4), .add_co(add_co4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_sum(out_sum4), .out_co(out_co4), .busy(busy4)
    );

    mp_add_seq #(.SIZE(4), .WORDS(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_ci(in_ci1),
        .add_a(add_a1), .add_b(add_b1), .add_ci(add_ci1),
        .add_sum(add_sum1), .add_co(add_co1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_co(out_co1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before the test completed");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid4; returns the number of cycles since acceptance.
    task automatic wait_valid4(output int cyc, output logic [15:0] alog, output logic [3:0] cilog);
        cyc   = 1;
        alog  = '0;
        cilog = '0;
        while (!out_valid4 && cyc < 20) begin
            if (cyc <= 4) begin
                alog[(cyc-1)*4 +: 4] = add_a4;
                cilog[cyc-1]         = add_ci4;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic run_op4(input vec_t v);
        int          cyc;
        logic [15:0] alog;
        logic [3:0]  cilog;
        exp_t        e;
        in_a4     = v.a;
        in_b4     = v.b;
        in_ci4    = v.ci;
        in_valid4 = 1'b1;
        check("accept_ready", 32'(in_ready4), 32'd1);
        sb4.push_back('{v.sum, v.co, 0});
        tick();
        in_valid4 = 1'b0;
        in_a4     = ~v.a;    // must be ignored during RUN
        in_b4     = ~v.b;
        in_ci4    = ~v.ci;
        wait_valid4(cyc, alog, cilog);
        check("latency", 32'(cyc), 32'd5);
        check("add_a_seq", 32'(alog), 32'(v.a));
        check("add_ci_seq", 32'(cilog), 32'(v.ci_seq));
        check("add_zero_done", {27'd0, add_a4, add_ci4}, 32'd0);
        if (sb4.size() > 0) begin
            e = sb4.pop_front();
            check("sum", 32'(out_sum4), 32'(e.sum));
            check("co", 32'(out_co4), 32'(e.co));
        end
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        check("valid_drop", 32'(out_valid4), 32'd0);
        check("ready_back", 32'(in_ready4), 32'd1);
    endtask

    initial begin
        int          cyc;
        logic [15:0] alog;
        logic [3:0]  cilog;
        logic [15:0] s0;
        logic        c0;
        exp_t        e;
        logic [3:0]  ops1[4][3];
        logic [3:0]  exp1[4][2];
        int          nop, done1, last_acc;
        logic        acc_pending;

        checks = 0;
        errors = 0;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 4'hE};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'hE};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 4'h1};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 4'hF};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 4'h0};
        vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 4'hE};
        vecs[6] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 4'h0};

        rst        = 1'b1;
        in_valid4  = 1'b0; in_a4 = '0; in_b4 = '0; in_ci4 = 1'b0; out_ready4 = 1'b0;
        in_valid1  = 1'b0; in_a1 = '0; in_b1 = '0; in_ci1 = 1'b0; out_ready1 = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready4), 32'd1);
        check("rst_out_valid", 32'(out_valid4), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_out", {15'd0, out_co4, out_sum4}, 32'd0);
        check("rst_add", {23'd0, add_a4, add_b4, add_ci4}, 32'd0);
        rst = 1'b0;
        tick();

        // Table-driven operations
        for (int i = 0; i < 6; i++) begin
            run_op4(vecs[i]);
        end

        // Backpressure: 0x00FF + 0x0001
        in_a4 = 16'h00FF; in_b4 = 16'h0001; in_ci4 = 1'b0; in_valid4 = 1'b1;
        sb4.push_back('{16'h0100, 1'b0, 0});
        tick();
        in_valid4 = 1'b0;
        wait_valid4(cyc, alog, cilog);
        check("bp_latency", 32'(cyc), 32'd5);
        s0 = out_sum4;
        c0 = out_co4;
        if (sb4.size() > 0) begin
            e = sb4.pop_front();
            check("bp_sum", 32'(out_sum4), 32'(e.sum));
            check("bp_co", 32'(out_co4), 32'(e.co));
        end
        in_valid4 = 1'b1;
        in_a4     = 16'hAAAA;
        in_b4     = 16'h5555;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_valid_hold", 32'(out_valid4), 32'd1);
            check("bp_sum_stable", {15'd0, out_co4, out_sum4}, {15'd0, c0, s0});
            check("bp_in_ready_low", 32'(in_ready4), 32'd0);
        end
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        check("bp_valid_drop", 32'(out_valid4), 32'd0);
        check("bp_ready_back", 32'(in_ready4), 32'd1);
        check("bp_not_busy", 32'(busy4), 32'd0);

        // Reset on the second RUN cycle aborts the operation
        in_a4 = 16'h5555; in_b4 = 16'h1111; in_ci4 = 1'b1; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        tick();
        check("mid_busy", 32'(busy4), 32'd1);
        rst = 1'b1;
        tick();
        check("abort_busy", 32'(busy4), 32'd0);
        check("abort_valid", 32'(out_valid4), 32'd0);
        check("abort_ready", 32'(in_ready4), 32'd1);
        check("abort_add", {23'd0, add_a4, add_b4, add_ci4}, 32'd0);
        rst = 1'b0;
        tick();
        run_op4(vecs[6]);

        // WORDS=1 back-to-back with out_ready tied high
        ops1[0] = '{4'h9, 4'h8, 4'h1}; exp1[0] = '{4'h2, 4'h1};
        ops1[1] = '{4'h3, 4'h4, 4'h0}; exp1[1] = '{4'h7, 4'h0};
        ops1[2] = '{4'hF, 4'hF, 4'h1}; exp1[2] = '{4'hF, 4'h1};
        ops1[3] = '{4'h0, 4'h0, 4'h0}; exp1[3] = '{4'h0, 4'h0};
        nop         = 0;
        done1       = 0;
        last_acc    = -1;
        acc_pending = 1'b0;
        cyc         = 0;
        in_a1 = ops1[0][0]; in_b1 = ops1[0][1]; in_ci1 = ops1[0][2][0];
        in_valid1 = 1'b1;
        while (done1 < 4 && cyc < 60) begin
            if (out_valid1) begin
                if (sb1.size() > 0) begin
                    e = sb1.pop_front();
                    check("w1_sum", 32'(out_sum1), 32'(e.sum));
                    check("w1_co", 32'(out_co1), 32'(e.co));
                    check("w1_latency", 32'(cyc - e.acc), 32'd2);
                end else begin
                    check("w1_unexpected_output", 32'd1, 32'd0);
                end
                done1++;
            end
            if (in_valid1 && in_ready1) begin
                sb1.push_back('{{12'd0, exp1[nop][0]}, exp1[nop][1][0], cyc});
                if (last_acc >= 0) begin
                    check("w1_spacing", 32'(cyc - last_acc), 32'd3);
                end
                last_acc    = cyc;
                acc_pending = 1'b1;
            end
            tick();
            cyc++;
            if (acc_pending) begin
                acc_pending = 1'b0;
                nop++;
                if (nop < 4) begin
                    in_a1 = ops1[nop][0]; in_b1 = ops1[nop][1]; in_ci1 = ops1[nop][2][0];
                end else begin
                    in_valid1 = 1'b0;
                end
            end
        end
        check("w1_all_done", 32'(done1), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
